// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scan driver:
// segment table, blank pattern, shadow-register layout and timing helpers.
package seg7_pkg;

    // Common-anode abcdefg pattern with every segment off.
    localparam logic [6:0] SegBlank = 7'b1111111;

    // Common-anode abcdefg patterns indexed by value; 10-15 render as blank.
    localparam logic [15:0][6:0] SegTable = {
        SegBlank,   // 15
        SegBlank,   // 14
        SegBlank,   // 13
        SegBlank,   // 12
        SegBlank,   // 11
        SegBlank,   // 10
        7'b0000100, // 9
        7'b0000000, // 8
        7'b0001111, // 7
        7'b0100000, // 6
        7'b0100100, // 5
        7'b1001100, // 4
        7'b0000110, // 3
        7'b0010010, // 2
        7'b1001111, // 1
        7'b0000001  // 0
    };

    // Inputs captured once per frame; the display is driven only from these.
    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  blink_mask;
        logic        lz_blank;
        logic [3:0]  brightness;
    } shadow_t;

    // Clock cycles each digit stays selected.
    function automatic int unsigned dig_duration(int unsigned freq, int unsigned scan_per_sec);
        return freq / (4 * scan_per_sec);
    endfunction

    // Clock cycles per blink half-period.
    function automatic int unsigned half_blink(int unsigned freq, int unsigned blink_hz);
        return freq / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to common-anode abcdefg decoder; values 10-15 decode blank.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = SegTable[val_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame shadow registers,
// PWM brightness, per-digit blink and leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CC           = 1,
    parameter int unsigned FREQ         = 2_000,
    parameter int unsigned SCAN_PER_SEC = 25,
    parameter int unsigned BLINK_HZ     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blink_mask_i,
    input  logic        lz_blank_i,
    input  logic [3:0]  brightness_i,
    output logic [7:0]  seven_seg,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    localparam int unsigned DigDur    = dig_duration(FREQ, SCAN_PER_SEC);
    localparam int unsigned HalfBlink = half_blink(FREQ, BLINK_HZ);
    localparam int unsigned SlotW     = (DigDur > 1) ? $clog2(DigDur) : 1;
    localparam int unsigned BlinkW    = (HalfBlink > 1) ? $clog2(HalfBlink) : 1;

    localparam logic [SlotW-1:0]  SlotLast  = SlotW'(DigDur - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(HalfBlink - 1);

    // Common-cathode boards invert both segment and digit polarity.
    localparam logic [7:0] SegInv = (CC != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] EnInv  = (CC != 0) ? 4'hF : 4'h0;

    logic [SlotW-1:0]  slot_q, slot_d;
    logic [1:0]        dig_q, dig_d;
    logic [3:0]        pwm_q, pwm_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              pend_q, pend_d;
    shadow_t           shadow_q, shadow_d;
    logic              frame_start_q, frame_start_d;
    logic [7:0]        seven_seg_q, seven_seg_d;
    logic [3:0]        digit_en_q, digit_en_d;

    logic              slot_wrap;
    logic              blink_wrap;
    logic              load;
    logic [3:0]        cur_val;
    logic [6:0]        dec_seg;
    logic [3:0]        lz_hide;
    logic              dark;
    logic [7:0]        seg_ca;
    logic [3:0]        en_ca;

    seg7_decoder u_decoder (
        .val_i (cur_val),
        .seg_o (dec_seg)
    );

    // Scan, PWM and blink timebases plus the once-per-frame shadow load.
    always_comb begin
        slot_wrap  = (slot_q == SlotLast);
        blink_wrap = (blink_cnt_q == BlinkLast);
        // Load at the 3->0 digit wrap, or on the first edge after reset.
        load       = (slot_wrap && (dig_q == 2'd3)) || pend_q;

        slot_d        = slot_wrap ? '0 : slot_q + SlotW'(1);
        dig_d         = slot_wrap ? dig_q + 2'd1 : dig_q;
        pwm_d         = pwm_q + 4'd1;
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
        pend_d        = 1'b0;
        frame_start_d = load;

        shadow_d = shadow_q;
        if (load) begin
            shadow_d.bcd        = bcd_i;
            shadow_d.dp         = dp_i;
            shadow_d.blink_mask = blink_mask_i;
            shadow_d.lz_blank   = lz_blank_i;
            shadow_d.brightness = brightness_i;
        end
    end

    // Pattern for the currently selected digit, registered one cycle later.
    always_comb begin
        cur_val = shadow_q.bcd[{dig_q, 2'b00} +: 4];

        // A digit is a leading zero when it and every digit to its left are zero.
        lz_hide[3] = (shadow_q.bcd[15:12] == 4'd0);
        lz_hide[2] = lz_hide[3] && (shadow_q.bcd[11:8] == 4'd0);
        lz_hide[1] = lz_hide[2] && (shadow_q.bcd[7:4] == 4'd0);
        lz_hide[0] = 1'b0;

        dark = (shadow_q.lz_blank && lz_hide[dig_q])
            || (blink_phase_q && shadow_q.blink_mask[dig_q])
            || (pwm_q > shadow_q.brightness);

        if (dark) begin
            seg_ca = {1'b1, SegBlank};
            en_ca  = 4'h0;
        end else begin
            seg_ca = {~shadow_q.dp[dig_q], dec_seg};
            en_ca  = 4'b0001 << dig_q;
        end

        seven_seg_d = seg_ca ^ SegInv;
        digit_en_d  = en_ca ^ EnInv;
    end

    // State registers; reset arms the pending load so scanning restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            dig_q         <= 2'd0;
            pwm_q         <= 4'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_q        <= 1'b1;
            shadow_q      <= '0;
            frame_start_q <= 1'b0;
            seven_seg_q   <= 8'hFF ^ SegInv;
            digit_en_q    <= 4'h0 ^ EnInv;
        end else begin
            slot_q        <= slot_d;
            dig_q         <= dig_d;
            pwm_q         <= pwm_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_q        <= pend_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            seven_seg_q   <= seven_seg_d;
            digit_en_q    <= digit_en_d;
        end
    end

    assign seven_seg   = seven_seg_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter CC, default 1: 0 = common-anode (active-low segments, active-high digit_en), 1 = common-cathode (both polarities inverted).
REQ-002 SHALL have parameter FREQ, default 2_000: clk frequency in Hz.
REQ-003 SHALL have parameter SCAN_PER_SEC, default 25: full 4-digit frames per second.
REQ-004 SHALL have parameter BLINK_HZ, default 2: blink on/off rate in Hz.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port bcd_i, input, 16: digits {d3,d2,d1,d0}, 4 bits each; d0 is the rightmost digit.
REQ-008 SHALL have port dp_i, input, 4: decimal-point enable per digit.
REQ-009 SHALL have port blink_mask_i, input, 4: per-digit blink enable.
REQ-010 SHALL have port lz_blank_i, input, 1: leading-zero blanking enable.
REQ-011 SHALL have port brightness_i, input, 4: duty level; 15 = full.
REQ-012 SHALL have port seven_seg, output, 8: {dp,a,b,c,d,e,f,g}, registered.
REQ-013 SHALL have port digit_en, output, 4: one-hot digit select, registered.
REQ-014 SHALL have port frame_start, output, 1: one-cycle pulse when the shadow inputs load.

Function
REQ-015 SHALL derive DIG_DURATION = FREQ/(4*SCAN_PER_SEC) and HALF_BLINK = FREQ/(2*BLINK_HZ), both integer-truncated, and assume both are >= 1.
REQ-016 SHALL have a slot counter that runs 0..DIG_DURATION-1 and, on wrap, increments the 2-bit dig_cnt modulo 4 in order 0,1,2,3,0.
REQ-017 SHALL load the shadow registers (bcd, dp, blink_mask, lz_blank, brightness) and pulse frame_start for one cycle on the same clock edge at which:
- dig_cnt wraps 3->0; or
- on the first clk edge after rst deasserts (reset-set pending flag, cleared by that load).
REQ-018 SHALL drive the display only from the shadow registers; input changes mid-frame SHALL have no visible effect before the next frame_start.
REQ-019 SHALL run a 4-bit pwm_cnt that free-runs every clk; the selected digit is lit only while pwm_cnt <= shadow brightness (0 -> 1/16 duty, 15 -> always lit).
REQ-020 SHALL toggle blink_phase every HALF_BLINK cycles; while blink_phase = 1, digits whose shadow blink_mask bit is set SHALL be blanked.
REQ-021 SHALL apply leading-zero blanking when shadow lz_blank = 1:
- d3 blanked if d3 = 0;
- d2 blanked if d3 = d2 = 0;
- d1 blanked if d3 = d2 = d1 = 0;
- d0 is never blanked.
REQ-022 SHALL decode values 0-9 with common-anode patterns abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 SHALL turn all seven segments off for values 10-15, while dp is still driven from dp_i.
REQ-024 SHALL, for a blanked or PWM-off digit, drive digit_en all inactive and seven_seg all inactive (dp included).
REQ-025 SHALL register outputs so that seven_seg/digit_en reflect dig_cnt, pwm_cnt and blink_phase with exactly 1 clk latency.
REQ-026 SHALL, when CC=1, invert both seven_seg and digit_en relative to the CC=0 encoding.

Reset
REQ-027 SHALL, while rst is high, hold:
- slot counter, dig_cnt, pwm_cnt, blink counter, blink_phase and all shadow registers at 0;
- frame_start at 0;
- seven_seg inactive (8'hFF for CC=0, 8'h00 for CC=1);
- digit_en inactive (4'h0 for CC=0, 4'hF for CC=1).
REQ-028 SHALL set the load-pending flag on reset, so that an assertion mid-frame restarts scanning at digit 0 with a fresh shadow load.

Structure
REQ-029 SHALL place the segment pattern table, the blank pattern and the DIG_DURATION/HALF_BLINK computation in the shared seg7_pkg package.
REQ-030 SHALL implement the BCD-to-segment decode as the combinational sub-module seg7_decoder (4-bit value in, 7-bit common-anode pattern out).

Verification (CC=0, FREQ=2000, SCAN_PER_SEC=25, BLINK_HZ=2; DIG_DURATION=20, HALF_BLINK=500)
REQ-031 SHALL check scan order: bcd_i=16'h1234, brightness 15 -> digit_en 0001,0010,0100,1000, each held 20 cycles; seven_seg[6:0] = 1001100, 0000110, 0010010, 1001111 respectively.
REQ-032 SHALL check shadow timing: change bcd_i from 16'h1234 to 16'h5678 mid-frame -> display unchanged until the frame_start pulse, then shows 5678 beginning with digit 0.
REQ-033 SHALL check leading-zero blanking: bcd_i=16'h0050, lz_blank_i=1 -> d3 and d2 slots have digit_en=0000 and seven_seg=8'hFF; d1 shows 5; d0 shows 0. With bcd_i=16'h0000, only d0 lights.
REQ-034 SHALL check PWM: brightness 3 -> within each 16-cycle window digit_en is active exactly 4 cycles (pwm_cnt 0-3).
REQ-035 SHALL check blink: blink_mask_i=4'b0001 -> d0 lit for 500 cycles, dark for 500; other digits unaffected.
REQ-036 SHALL check reset: assert rst while dig_cnt=2 -> outputs inactive immediately (asynchronous); after release, frame_start pulses on the first edge and scanning restarts at digit 0.
